// File: rtl/sdr_req_arb.sv
// ============================================================================
//  Module   : sdr_req_arb
//  Brief    : Two-requester round-robin front end for an SDRAM controller
//             application port, with a stall watchdog.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sdr_req_arb #(
    parameter int APP_AW = 26,
    parameter int dw     = 32,
    parameter int bl     = 9,
    parameter int TMO_W  = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              m0_req,
    input  logic [APP_AW-1:0] m0_addr,
    input  logic [bl-1:0]     m0_len,
    input  logic              m0_wr_n,
    input  logic [dw-1:0]     m0_wr_data,
    input  logic [dw/8-1:0]   m0_wr_en_n,
    output logic              m0_ack,
    output logic              m0_wr_next,
    output logic              m0_rd_valid,
    output logic              m0_last,

    input  logic              m1_req,
    input  logic [APP_AW-1:0] m1_addr,
    input  logic [bl-1:0]     m1_len,
    input  logic              m1_wr_n,
    input  logic [dw-1:0]     m1_wr_data,
    input  logic [dw/8-1:0]   m1_wr_en_n,
    output logic              m1_ack,
    output logic              m1_wr_next,
    output logic              m1_rd_valid,
    output logic              m1_last,

    output logic              app_req,
    output logic [APP_AW-1:0] app_req_addr,
    output logic [bl-1:0]     app_req_len,
    output logic              app_req_wr_n,
    output logic [dw-1:0]     app_wr_data,
    output logic [dw/8-1:0]   app_wr_en_n,
    input  logic              app_req_ack,
    input  logic              app_wr_next_req,
    input  logic              app_rd_valid,
    input  logic              app_last_rd,
    input  logic              app_last_wr,
    output logic [dw-1:0]     rd_data,
    input  logic [dw-1:0]     app_rd_data,
    output logic              arb_err,
    output logic              gnt_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ptr_q,   ptr_d;    // requester favoured on a tie
    logic                own_q,   own_d;
    logic                err_q,   err_d;
    logic [TMO_W-1:0]    wdog_q,  wdog_d;
    logic [APP_AW-1:0]   addr_q,  addr_d;
    logic [bl-1:0]       len_q,   len_d;
    logic                wrn_q,   wrn_d;

    logic                w_sel;
    logic                w_busy;
    logic                w_own_last;
    logic                w_wdog_max;

    assign w_sel      = (m0_req && m1_req) ? ptr_q : m1_req;
    assign w_busy     = (state_q != S_IDLE);
    assign w_own_last = wrn_q ? app_last_rd : app_last_wr;
    assign w_wdog_max = &wdog_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        err_d   = err_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wrn_d   = wrn_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = S_REQ;
                    own_d   = w_sel;
                    addr_d  = w_sel ? m1_addr : m0_addr;
                    len_d   = w_sel ? m1_len  : m0_len;
                    wrn_d   = w_sel ? m1_wr_n : m0_wr_n;
                end
            end
            S_REQ: begin
                if (app_req_ack) begin
                    state_d = S_XFER;
                end else if (w_wdog_max) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    ptr_d   = ~own_q;
                end
            end
            S_XFER: begin
                // a real completion takes priority over a coincident timeout
                if (w_own_last || w_wdog_max) begin
                    state_d = S_IDLE;
                    ptr_d   = ~own_q;
                    if (!w_own_last) err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q || state_q == S_IDLE) wdog_d = '0;
        else                                         wdog_d = wdog_q + TMO_W'(1);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            own_q   <= 1'b0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wrn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wrn_q   <= wrn_d;
        end
    end

    assign app_req      = (state_q == S_REQ);
    assign app_req_addr = addr_q;
    assign app_req_len  = len_q;
    assign app_req_wr_n = wrn_q;
    assign gnt_id       = own_q;
    assign arb_err      = err_q;
    assign rd_data      = app_rd_data;

    assign m0_ack       = app_req && app_req_ack && !own_q;
    assign m1_ack       = app_req && app_req_ack &&  own_q;

    // Strobes and write data only ever reach the current owner.
    assign app_wr_data  = !w_busy ? '0 : (own_q ? m1_wr_data : m0_wr_data);
    assign app_wr_en_n  = !w_busy ? '1 : (own_q ? m1_wr_en_n : m0_wr_en_n);

    assign m0_wr_next   = w_busy && !own_q && app_wr_next_req;
    assign m1_wr_next   = w_busy &&  own_q && app_wr_next_req;
    assign m0_rd_valid  = w_busy && !own_q && app_rd_valid;
    assign m1_rd_valid  = w_busy &&  own_q && app_rd_valid;
    assign m0_last      = w_busy && !own_q && w_own_last;
    assign m1_last      = w_busy &&  own_q && w_own_last;

endmodule

`default_nettype wire

// File: tb/tb_sdr_req_arb.sv
// ============================================================================
//  Module   : tb_sdr_req_arb
//  Brief    : Self-checking bench for sdr_req_arb: vector table, directed
//             multi-cycle sequences and a randomized run against a model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sdr_req_arb;

    localparam int APP_AW = 26;
    localparam int DW     = 32;
    localparam int BL     = 9;
    localparam int TMO_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req, m0_wr_n, m1_wr_n;
    logic [APP_AW-1:0] m0_addr, m1_addr;
    logic [BL-1:0]     m0_len, m1_len;
    logic [DW-1:0]     m0_wr_data, m1_wr_data, app_rd_data;
    logic [DW/8-1:0]   m0_wr_en_n, m1_wr_en_n;
    logic              m0_ack, m0_wr_next, m0_rd_valid, m0_last;
    logic              m1_ack, m1_wr_next, m1_rd_valid, m1_last;
    logic              app_req, app_req_wr_n;
    logic [APP_AW-1:0] app_req_addr;
    logic [BL-1:0]     app_req_len;
    logic [DW-1:0]     app_wr_data, rd_data;
    logic [DW/8-1:0]   app_wr_en_n;
    logic              app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr;
    logic              arb_err, gnt_id;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdr_req_arb #(.APP_AW(APP_AW), .dw(DW), .bl(BL), .TMO_W(TMO_W)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len), .m0_wr_n(m0_wr_n),
        .m0_wr_data(m0_wr_data), .m0_wr_en_n(m0_wr_en_n), .m0_ack(m0_ack),
        .m0_wr_next(m0_wr_next), .m0_rd_valid(m0_rd_valid), .m0_last(m0_last),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_len(m1_len), .m1_wr_n(m1_wr_n),
        .m1_wr_data(m1_wr_data), .m1_wr_en_n(m1_wr_en_n), .m1_ack(m1_ack),
        .m1_wr_next(m1_wr_next), .m1_rd_valid(m1_rd_valid), .m1_last(m1_last),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
        .app_req_ack(app_req_ack), .app_wr_next_req(app_wr_next_req),
        .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd), .app_last_wr(app_last_wr),
        .rd_data(rd_data), .app_rd_data(app_rd_data), .arb_err(arb_err), .gnt_id(gnt_id)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        app_req_ack = 0; app_wr_next_req = 0; app_rd_valid = 0;
        app_last_rd = 0; app_last_wr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        m0_req = 0; m1_req = 0;
        clr_ctl();
        repeat (2) nxt();
        rst = 0;
    endtask

    function automatic logic [9:0] ctl_now();
        return {app_req, gnt_id, m0_ack, m1_ack, m0_wr_next, m1_wr_next,
                m0_rd_valid, m1_rd_valid, m0_last, m1_last};
    endfunction

    // {m0r,m1r,ack,wnx,rdv,lw,lr} and expected
    // {app_req,gnt,ack0,ack1,wn0,wn1,rv0,rv1,l0,l1}
    typedef struct packed {
        logic [6:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t vt[17];

    // behavioural model state for the randomized run
    int                mph, mown, mlast, mtmr, merr;
    logic [APP_AW-1:0] maddr;
    logic [BL-1:0]     mlen;
    logic              mwr;

    initial begin
        int cnt, c0, c1, c2, g;
        int order[$];
        logic ack_seen0, ack_seen1, busy, olast, done;
        logic [9:0] e;

        rst = 1;
        m0_req = 0; m1_req = 0; m0_addr = 26'h100; m1_addr = 26'h2abc;
        m0_len = 9'd4; m1_len = 9'd8; m0_wr_n = 0; m1_wr_n = 1;
        m0_wr_data = 32'hA5A5_0001; m1_wr_data = 32'h5A5A_0002;
        m0_wr_en_n = 4'h3; m1_wr_en_n = 4'hC; app_rd_data = 32'hDEAD_BEEF;
        clr_ctl();

        // ---- reset state, with activity on the inputs ----
        #3;
        m0_req = 1; m1_req = 1; app_wr_next_req = 1; app_rd_valid = 1; app_last_wr = 1;
        @(negedge clk);
        chk("rst_ctl", ctl_now(), 10'b0);
        chk("rst_err", arb_err, 0);
        chk("rst_wdata", app_wr_data, 0);
        chk("rst_wen", app_wr_en_n, 4'hF);
        chk("rst_addr", {app_req_addr, app_req_len, app_req_wr_n}, 0);
        chk("rd_pass", rd_data, 32'hDEAD_BEEF);
        do_reset();

        // ---- vector table ----
        vt[0]  = '{7'b1000000, 10'b0000000000};
        vt[1]  = '{7'b1000000, 10'b1000000000};
        vt[2]  = '{7'b1010000, 10'b1010000000};
        vt[3]  = '{7'b0001000, 10'b0000100000};
        vt[4]  = '{7'b0001100, 10'b0000101000};
        vt[5]  = '{7'b0001001, 10'b0000100000};
        vt[6]  = '{7'b0001010, 10'b0000100010};
        vt[7]  = '{7'b0101000, 10'b0000000000};
        vt[8]  = '{7'b0110000, 10'b1101000000};
        vt[9]  = '{7'b0000110, 10'b0100000100};
        vt[10] = '{7'b0000101, 10'b0100000101};
        vt[11] = '{7'b1100000, 10'b0100000000};
        vt[12] = '{7'b1100000, 10'b1000000000};
        vt[13] = '{7'b1110000, 10'b1010000000};
        vt[14] = '{7'b0100010, 10'b0000000010};
        vt[15] = '{7'b1100000, 10'b0000000000};
        vt[16] = '{7'b1100000, 10'b1100000000};
        for (int i = 0; i < 17; i++) begin
            {m0_req, m1_req, app_req_ack, app_wr_next_req, app_rd_valid,
             app_last_wr, app_last_rd} = vt[i].in;
            @(negedge clk);
            chk($sformatf("vec%0d", i), ctl_now(), vt[i].exp);
            nxt();
        end

        // ---- m0 write 0x100 len 4, request withdrawn before ack ----
        do_reset();
        m0_req = 1;
        @(negedge clk); chk("a_req_lat0", app_req, 0);
        nxt(); m0_req = 0;
        @(negedge clk);
        chk("a_req_fields", {app_req, app_req_addr, app_req_len, app_req_wr_n},
            {1'b1, 26'h100, 9'd4, 1'b0});
        repeat (3) nxt();
        @(negedge clk); chk("a_req_held", app_req, 1);
        nxt(); app_req_ack = 1;
        @(negedge clk); chk("a_ack", {m0_ack, m1_ack}, 2'b10);
        nxt(); clr_ctl();
        @(negedge clk); chk("a_wmux", {app_wr_data, app_wr_en_n}, {32'hA5A5_0001, 4'h3});
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            app_wr_next_req = 1; app_last_wr = (k == 3);
            @(negedge clk); cnt += m0_wr_next;
            nxt();
        end
        clr_ctl();
        chk("a_wr_next_cnt", cnt, 4);
        @(negedge clk);
        chk("a_idle", {app_req, app_wr_data, app_wr_en_n}, {1'b0, 32'h0, 4'hF});

        // ---- back-to-back alternation ----
        do_reset();
        m0_req = 1; m1_req = 1; app_req_ack = 1; app_last_wr = 1; app_last_rd = 1;
        cnt = 0;
        while (order.size() < 4 && cnt < 100) begin
            @(negedge clk);
            if (m0_ack) order.push_back(0);
            if (m1_ack) order.push_back(1);
            if (m0_ack || m1_ack) chk("b_gnt_at_ack", gnt_id, m1_ack);
            nxt(); cnt++;
        end
        chk("b_count", order.size(), 4);
        for (int k = 0; k < order.size(); k++) chk($sformatf("b_order%0d", k), order[k], k % 2);

        // ---- m1 read len 8 ----
        do_reset();
        m1_req = 1; app_req_ack = 1;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (m1_ack || cnt >= 20) break;
            nxt(); cnt++;
        end
        chk("c_got_ack", m1_ack, 1);
        nxt(); clr_ctl(); m1_req = 0;
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 0; k < 9; k++) begin
            app_rd_valid = 1; app_last_rd = (k == 7); app_last_wr = 1;
            @(negedge clk);
            c1 += m1_rd_valid; c2 += m1_last; c0 += m0_rd_valid + m0_last;
            nxt();
        end
        clr_ctl();
        chk("c_rd_valid_cnt", c1, 8);
        chk("c_last_cnt", c2, 1);
        chk("c_m0_quiet", c0, 0);

        // ---- watchdog ----
        do_reset();
        m0_req = 1; m1_req = 1;
        cnt = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (app_req) cnt++;
            else if (cnt > 0) break;
            nxt();
        end
        chk("d_req_cycles", cnt, 1 << TMO_W);
        chk("d_err_idle", {arb_err, app_req, gnt_id}, 3'b100);
        nxt();
        @(negedge clk);
        chk("d_next_gnt", {arb_err, app_req, gnt_id}, 3'b111);

        // ---- reset during XFER, then during REQ ----
        do_reset();
        m0_req = 1; app_req_ack = 1;
        nxt(); nxt(); clr_ctl(); m0_req = 0; m1_req = 1;   // XFER from here
        app_wr_next_req = 1;
        repeat (3) nxt();
        @(negedge clk); chk("e_pre", m0_wr_next, 1);
        #2 rst = 1; #1;
        chk("e_async", {ctl_now(), app_wr_en_n}, {10'b0, 4'hF});
        nxt(); nxt(); clr_ctl(); rst = 0;
        @(negedge clk); chk("e_m1_first_idle", app_req, 0);
        nxt();
        @(negedge clk); chk("e_m1_first", {app_req, gnt_id}, 2'b11);
        #1 rst = 1; app_req_ack = 1; #1;
        chk("e_req_drop", {app_req, m0_ack, m1_ack, gnt_id}, 4'b0);
        nxt(); clr_ctl(); m0_req = 1; m1_req = 1; nxt(); rst = 0;
        nxt();
        @(negedge clk); chk("e_m0_wins", {app_req, gnt_id}, 2'b10);

        // ---- randomized run against the behavioural model ----
        do_reset();
        mph = 0; mown = 0; mlast = 1; mtmr = 0; merr = 0;
        maddr = '0; mlen = '0; mwr = 0;
        ack_seen0 = 0; ack_seen1 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ack_seen0) m0_req = 0;
            else if (!m0_req && $urandom_range(3) == 0) begin
                m0_req = 1; m0_addr = APP_AW'($urandom); m0_len = BL'($urandom); m0_wr_n = 1'($urandom);
            end
            if (ack_seen1) m1_req = 0;
            else if (!m1_req && $urandom_range(3) == 0) begin
                m1_req = 1; m1_addr = APP_AW'($urandom); m1_len = BL'($urandom); m1_wr_n = 1'($urandom);
            end
            m0_wr_data = $urandom; m1_wr_data = $urandom;
            m0_wr_en_n = 4'($urandom); m1_wr_en_n = 4'($urandom);
            app_req_ack = 1'($urandom); app_wr_next_req = 1'($urandom);
            app_rd_valid = 1'($urandom);
            app_last_wr = ($urandom_range(4) == 0); app_last_rd = ($urandom_range(4) == 0);
            @(negedge clk);

            busy  = (mph != 0);
            olast = mwr ? app_last_rd : app_last_wr;
            e = {mph == 1, mown[0], mph == 1 && app_req_ack && mown == 0,
                 mph == 1 && app_req_ack && mown == 1,
                 busy && mown == 0 && app_wr_next_req, busy && mown == 1 && app_wr_next_req,
                 busy && mown == 0 && app_rd_valid,    busy && mown == 1 && app_rd_valid,
                 busy && mown == 0 && olast,           busy && mown == 1 && olast};
            chk($sformatf("rnd_ctl@%0d", cyc), ctl_now(), e);
            chk($sformatf("rnd_wmux@%0d", cyc), {app_wr_data, app_wr_en_n},
                !busy ? {32'h0, 4'hF} : (mown == 1 ? {m1_wr_data, m1_wr_en_n} : {m0_wr_data, m0_wr_en_n}));
            if (mph == 1)
                chk($sformatf("rnd_fields@%0d", cyc), {app_req_addr, app_req_len, app_req_wr_n},
                    {maddr, mlen, mwr});
            chk($sformatf("rnd_err@%0d", cyc), arb_err, merr[0]);
            ack_seen0 = m0_ack; ack_seen1 = m1_ack;

            // model: a tie goes to whoever was not served last
            if (mph == 0) begin
                if (m0_req || m1_req) begin
                    g = (m0_req && m1_req) ? (mlast == 0 ? 1 : 0) : (m1_req ? 1 : 0);
                    mown = g;
                    maddr = g ? m1_addr : m0_addr;
                    mlen  = g ? m1_len  : m0_len;
                    mwr   = g ? m1_wr_n : m0_wr_n;
                    mph = 1; mtmr = 0;
                end
            end else begin
                done = (mph == 1) ? app_req_ack : olast;
                if (done) begin
                    if (mph == 1) mph = 2;
                    else begin mph = 0; mlast = mown; end
                    mtmr = 0;
                end else if (mtmr == (1 << TMO_W) - 1) begin
                    mph = 0; merr = 1; mlast = mown; mtmr = 0;
                end else mtmr++;
            end
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sdr_req_arb.md
SDR_REQ_ARB -- requirements
Module: sdr_req_arb

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  APP_AW, 26, application address width.
  dw, 32, application data width.
  bl, 9, burst length width.
  TMO_W, 10, watchdog counter width; timeout = 2**TMO_W cycles.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
  wb_clk_i  in  1  clock.
  wb_rst_i  in  1  reset.
REQ-003 Requester ports SHALL exist for N=0,1, one per line: name, direction, width, meaning.
  mN_req  in  1  request; held until mN_ack.
  mN_addr  in  APP_AW  request address.
  mN_len  in  bl  burst length.
  mN_wr_n  in  1  0=write, 1=read.
  mN_wr_data  in  dw  write data.
  mN_wr_en_n  in  dw/8  active-low byte enables.
  mN_ack  out  1  request accepted (1-cycle pulse).
  mN_wr_next  out  1  write data consumed.
  mN_rd_valid  out  1  read data valid.
  mN_last  out  1  last beat of own burst.
REQ-004 Controller-side ports SHALL be, one per line:
  app_req  out  1  request.
  app_req_addr  out  APP_AW  address.
  app_req_len  out  bl  length.
  app_req_wr_n  out  1  direction.
  app_wr_data  out  dw  write data.
  app_wr_en_n  out  dw/8  byte enables.
  app_req_ack  in  1  request accepted.
  app_wr_next_req  in  1  write beat taken.
  app_rd_valid  in  1  read beat valid.
  app_last_rd  in  1  last read beat.
  app_last_wr  in  1  last write beat.
  rd_data  out  dw  app_rd_data pass-through, shared by both requesters.
  app_rd_data  in  dw  read data.
  arb_err  out  1  sticky watchdog error.
  gnt_id  out  1  current owner.

Function
REQ-005 FSM SHALL have exactly three states: IDLE, REQ, XFER.
REQ-006 In IDLE with exactly one mN_req high, the block SHALL grant that requester.
REQ-007 In IDLE with both requests high, the block SHALL grant the requester not granted last (round-robin pointer).
REQ-008 On grant, the block SHALL latch addr, len, wr_n and the owner, set gnt_id, and move to REQ on the next edge.
REQ-009 In REQ, app_req SHALL be 1 with the latched fields; in IDLE and XFER, app_req SHALL be 0.
REQ-010 On app_req_ack=1 in REQ, the block SHALL pulse the owner's mN_ack in that same cycle (combinational) and move to XFER.
REQ-011 In XFER the block SHALL return to IDLE on app_last_wr (write) or app_last_rd (read), and update the pointer.
REQ-012 A new grant SHALL be made no earlier than the cycle after the return to IDLE (one idle cycle minimum).
REQ-013 app_wr_data and app_wr_en_n SHALL mux the owner's signals combinationally; with no owner they SHALL be 0 and all ones respectively.
REQ-014 app_wr_next_req, app_rd_valid and the matching last SHALL route combinationally to the owner only; the non-owner's copies SHALL be 0.
REQ-015 Strobes arriving in IDLE SHALL be dropped, and the watchdog SHALL NOT count in IDLE.
REQ-016 The TMO_W-bit watchdog SHALL clear on every state change and count in REQ and XFER.
REQ-017 Watchdog rollover at all ones SHALL set arb_err (sticky until reset), force IDLE and advance the pointer.
REQ-018 A requester dropping mN_req before ack SHALL NOT cancel the latched request.

Reset
REQ-019 While wb_rst_i=1, the block SHALL hold: state=IDLE; pointer favouring m0; gnt_id=0; arb_err=0; watchdog=0; latched fields=0; all outputs per REQ-009/013/014 inactive.
REQ-020 Asserting wb_rst_i mid-REQ or mid-XFER SHALL drop app_req immediately (async), without an ack pulse.

Verification
REQ-021 m0 write addr 0x100, len 4 alone: app_req 1 cycle after req; m0_ack with app_req_ack; 4 m0_wr_next; IDLE after app_last_wr.
REQ-022 m0 and m1 requesting simultaneously from reset: grant order m0, m1, m0, m1; gnt_id toggles each transaction.
REQ-023 m1 read len 8: exactly 8 m1_rd_valid and one m1_last; m0_rd_valid stays 0 throughout.
REQ-024 app_req_ack withheld for 1024 cycles (TMO_W=10): arb_err=1, state IDLE, next grant goes to the other requester.
REQ-025 Reset asserted 3 cycles into XFER: outputs reach reset values asynchronously; after release, a pending m1_req is granted first only if m0_req is low.
